// File: rtl/burst_frame_packer_if.sv
// Capture/drain handshake bundle for burst_frame_packer.
// Optional out_sum member is present only when BURST_FRAME_SUM_EN is defined.
interface burst_frame_packer_if #(
  parameter int DW    = 4,
  parameter int DEPTH = 8
);
  localparam int PW = $clog2(DEPTH);

  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eof;
  logic          done;
`ifdef BURST_FRAME_SUM_EN
  logic [DW+PW-1:0] out_sum;
`endif

  modport master (
    output start, in_valid, in_data, out_ready,
`ifdef BURST_FRAME_SUM_EN
    input  out_sum,
`endif
    input  busy, out_valid, out_data, out_sof, out_eof, done
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
`ifdef BURST_FRAME_SUM_EN
    output out_sum,
`endif
    output busy, out_valid, out_data, out_sof, out_eof, done
  );
endinterface

// File: rtl/burst_frame_packer.sv
// Captures DEPTH samples into a register buffer, then replays them as a framed
// valid/ready stream. Define BURST_FRAME_SUM_EN to add the out_sum accumulator.
module burst_frame_packer #(
  parameter int DW    = 4,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  burst_frame_packer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] ZERO_PTR = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [DW-1:0] buf_r [DEPTH];
  logic          done_r;
  logic          start_acc_s;
  logic          wr_en_s;
  logic          last_wr_s;
  logic          accept_s;
  logic          last_rd_s;

  // Handshake qualifiers and next-state selection
  always_comb begin
    start_acc_s = 1'b0;
    wr_en_s     = 1'b0;
    last_wr_s   = 1'b0;
    accept_s    = 1'b0;
    last_rd_s   = 1'b0;
    state_s     = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          start_acc_s = 1'b1;
          state_s     = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        wr_en_s   = bus.in_valid;
        last_wr_s = bus.in_valid && (wr_ptr_r == LAST_PTR);
        if (last_wr_s) begin
          state_s = DRAIN;
        end else begin
          state_s = FILL;
        end
      end
      DRAIN: begin
        accept_s  = bus.out_ready;
        last_rd_s = bus.out_ready && (rd_ptr_r == LAST_PTR);
        if (last_rd_s) begin
          state_s = IDLE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, pointers and done pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      wr_ptr_r <= ZERO_PTR;
      rd_ptr_r <= ZERO_PTR;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      done_r  <= last_rd_s;
      if (start_acc_s) begin
        wr_ptr_r <= ZERO_PTR;
      end else if (wr_en_s && !last_wr_s) begin
        wr_ptr_r <= wr_ptr_r + ONE_PTR;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      // rd_ptr returns to 0 both when a frame is armed and when it completes
      if (last_wr_s || last_rd_s) begin
        rd_ptr_r <= ZERO_PTR;
      end else if (accept_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Sample buffer; contents survive between bursts and clear only on reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_r[i] <= {DW{1'b0}};
      end
    end else if (wr_en_s) begin
      buf_r[wr_ptr_r] <= bus.in_data;
    end else begin
      buf_r <= buf_r;
    end
  end

  assign bus.busy      = (state_r != IDLE);
  assign bus.out_valid = (state_r == DRAIN);
  assign bus.out_data  = buf_r[rd_ptr_r];
  assign bus.out_sof   = (state_r == DRAIN) && (rd_ptr_r == ZERO_PTR);
  assign bus.out_eof   = (state_r == DRAIN) && (rd_ptr_r == LAST_PTR);
  assign bus.done      = done_r;

`ifdef BURST_FRAME_SUM_EN
  localparam int SW = DW + PW;
  logic [SW-1:0] sum_r;

  // Running sum of the samples captured in the current burst
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_r <= {SW{1'b0}};
    end else if (start_acc_s) begin
      sum_r <= {SW{1'b0}};
    end else if (wr_en_s) begin
      sum_r <= sum_r + SW'(bus.in_data);
    end else begin
      sum_r <= sum_r;
    end
  end

  assign bus.out_sum = sum_r;
`endif
endmodule

// File: tb/tb_burst_frame_packer.sv
// Directed self-checking bench for burst_frame_packer (DW=4, DEPTH=8).
// Sum checks are compiled in when BURST_FRAME_SUM_EN is defined.
module tb_burst_frame_packer;
  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [3:0] exp_mem [8];
  int   exp_sum;

  burst_frame_packer_if #(.DW(4), .DEPTH(8)) bus ();
  burst_frame_packer #(.DW(4), .DEPTH(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load(input logic [31:0] packed_vals);
    exp_sum = 0;
    for (int i = 0; i < 8; i++) begin
      exp_mem[i] = packed_vals[4*i +: 4];
      exp_sum += int'(exp_mem[i]);
    end
  endtask

  // Called at a negedge in FILL; returns at the negedge after the last write
  task automatic capture(input int gap);
    for (int i = 0; i < 8; i++) begin
      chk("fill_no_valid", bus.out_valid, 0);
      chk("fill_busy", bus.busy, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = exp_mem[i];
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 4'h0;
      if (i < 7) repeat (gap) @(negedge clk);
    end
  endtask

  // Drains 8 beats, optionally stalling on beat bp_beat; returns at the done negedge
  task automatic drain(input int bp_beat, input int bp_len);
    for (int i = 0; i < 8; i++) begin
      if (i == bp_beat) begin
        bus.out_ready = 1'b0;
        for (int k = 0; k < bp_len; k++) begin
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, exp_mem[i]);
          chk("stall_sof", bus.out_sof, (i == 0));
          @(negedge clk);
        end
      end
      bus.out_ready = 1'b1;
      chk("beat_valid", bus.out_valid, 1);
      chk("beat_data", bus.out_data, exp_mem[i]);
      chk("beat_sof", bus.out_sof, (i == 0));
      chk("beat_eof", bus.out_eof, (i == 7));
      chk("beat_busy", bus.busy, 1);
      chk("beat_no_done", bus.done, 0);
`ifdef BURST_FRAME_SUM_EN
      if (i == 7) chk("eof_sum", bus.out_sum, exp_sum);
`endif
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_no_valid", bus.out_valid, 0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 4'h0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // 1. Reset and idle
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sof", bus.out_sof, 0);
    chk("rst_eof", bus.out_eof, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_data", bus.out_data, 0);
`ifdef BURST_FRAME_SUM_EN
    chk("rst_sum", bus.out_sum, 0);
`endif
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'(i + 5);
      @(negedge clk);
      chk("idle_no_valid", bus.out_valid, 0);
      chk("idle_busy", bus.busy, 0);
    end
    bus.in_valid = 1'b0;

    // 2. Basic frame 1..8
    load(32'h8765_4321);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    capture(0);
    drain(-1, 0);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);

    // 3. Gapped input and backpressure on beat 3
    load(32'hE609_5C3A);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    capture(1);
    drain(2, 3);

    // 4. Start with coincident sample, start held through FILL and DRAIN
    load(32'h1234_5675);
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    capture(0);
    drain(-1, 0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("eof_start_ignored", bus.busy, 0);

    // start in the done cycle begins a new FILL
    load(32'h9ABC_DEF0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    capture(0);
    drain(-1, 0);
    load(32'hFFFF_FFFF);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_start_honoured", bus.busy, 1);
    capture(0);
    drain(-1, 0);

    // 5a. Reset after 4 captures
    load(32'h2468_ACE1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = exp_mem[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midfill_rst_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    chk("midfill_rst_data", bus.out_data, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("midfill_no_partial", bus.out_valid, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    capture(0);
    drain(-1, 0);

    // 5b. Reset after 5 beats drained
    load(32'h7531_BDF9);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    capture(0);
    bus.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("middrain_beat5", bus.out_data, exp_mem[5]);
    bus.out_ready = 1'b0;
    rstn = 1'b0;
    #1;
    chk("middrain_rst_valid", bus.out_valid, 0);
    chk("middrain_rst_data", bus.out_data, 0);
    chk("middrain_rst_eof", bus.out_eof, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("middrain_no_partial", bus.out_valid, 0);
    load(32'h8765_4321);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    capture(0);
    drain(-1, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
